// File: rtl/pulse_gen_scheduler.sv
// Round-robin scheduler sharing one pulse_generator between NUM_REQ requesters.
// Issues a burst of start strobes per grant, with gap spacing and an edge watchdog.
module pulse_gen_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int REPEAT_W  = 4,
   parameter int GAP_W     = 8,
   parameter int TIMEOUT_W = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*REPEAT_W-1:0]  req_repeat,
   input  logic [GAP_W-1:0]             gap_cycles,
   input  logic                         pg_ready,
   input  logic                         pg_pulse,
   output logic                         pg_start,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           done,
   output logic                         err,
   output logic                         busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_WAIT_RDY,
      S_IDLE,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO,
      S_GAP,
      S_DONE,
      S_ABORT
   } state_t;

   state_t               state, state_n;
   logic [IDX_W-1:0]     idx, idx_n, ptr, ptr_n, arb_idx;
   logic                 arb_hit;
   logic [REPEAT_W-1:0]  rem_cnt, rem_n;
   logic [GAP_W-1:0]     gap_cnt, gap_n;
   logic [TIMEOUT_W-1:0] wd, wd_n;
   logic [NUM_REQ-1:0]   onehot_n;

   function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
      return IDX_W'(v % NUM_REQ);
   endfunction

   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!arb_hit && req[wrap_idx(int'(ptr) + i)]) begin
            arb_hit = 1'b1;
            arb_idx = wrap_idx(int'(ptr) + i);
         end
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      ptr_n   = ptr;
      rem_n   = rem_cnt;
      gap_n   = gap_cnt;
      wd_n    = wd;
      case (state)
         S_WAIT_RDY: if (pg_ready) state_n = S_IDLE;
         S_IDLE: begin
            if (!pg_ready) begin
               state_n = S_WAIT_RDY;
            end else if (arb_hit) begin
               state_n = S_START;
               idx_n   = arb_idx;
               rem_n   = req_repeat[int'(arb_idx)*REPEAT_W +: REPEAT_W];
            end
         end
         S_START: begin
            wd_n    = TIMEOUT_W'(1);
            state_n = S_WAIT_HI;
         end
         // watchdog starts at 1 so a timeout allows exactly 2^TIMEOUT_W-1 waiting cycles
         S_WAIT_HI: begin
            if (pg_pulse) begin
               state_n = S_WAIT_LO;
               wd_n    = TIMEOUT_W'(1);
            end else if (wd == '1) begin
               state_n = S_ABORT;
            end else begin
               wd_n = wd + 1'b1;
            end
         end
         S_WAIT_LO: begin
            if (!pg_pulse) begin
               if (rem_cnt == '0) begin
                  state_n = S_DONE;
               end else begin
                  rem_n = rem_cnt - 1'b1;
                  if (gap_cycles == '0) begin
                     state_n = S_START;
                  end else begin
                     state_n = S_GAP;
                     gap_n   = gap_cycles;
                  end
               end
            end else if (wd == '1) begin
               state_n = S_ABORT;
            end else begin
               wd_n = wd + 1'b1;
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_W'(1)) state_n = S_START;
            else gap_n = gap_cnt - 1'b1;
         end
         S_DONE: begin
            state_n = S_IDLE;
            ptr_n   = wrap_idx(int'(idx) + 1);
         end
         S_ABORT: state_n = S_WAIT_RDY;
         default: state_n = S_WAIT_RDY;
      endcase
      if (!pg_ready && (state inside {S_START, S_WAIT_HI, S_WAIT_LO, S_GAP}))
         state_n = S_ABORT;
   end

   assign onehot_n = NUM_REQ'(1) << idx_n;

   // outputs are registered from the next state so they align with the state they describe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_WAIT_RDY;
         idx      <= '0;
         ptr      <= '0;
         rem_cnt  <= '0;
         gap_cnt  <= '0;
         wd       <= '0;
         pg_start <= 1'b0;
         gnt      <= '0;
         done     <= '0;
         err      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         ptr      <= ptr_n;
         rem_cnt  <= rem_n;
         gap_cnt  <= gap_n;
         wd       <= wd_n;
         pg_start <= (state_n == S_START);
         err      <= (state_n == S_ABORT);
         busy     <= (state_n != S_IDLE);
         done     <= (state_n inside {S_DONE, S_ABORT}) ? onehot_n : '0;
         gnt      <= (state_n inside {S_START, S_WAIT_HI, S_WAIT_LO, S_GAP, S_DONE, S_ABORT})
                     ? onehot_n : '0;
      end
   end

endmodule

// File: tb/tb_pulse_gen_scheduler.sv
// Scoreboard bench for pulse_gen_scheduler with a behavioural pulse_generator model.
module tb_pulse_gen_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] req_repeat;
   logic [7:0]  gap_cycles;
   logic        pg_ready;
   logic        pg_pulse;
   logic        pg_start;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        err;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   pulse_gen_scheduler #(
      .NUM_REQ(4),
      .REPEAT_W(4),
      .GAP_W(8),
      .TIMEOUT_W(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .req_repeat(req_repeat),
      .gap_cycles(gap_cycles),
      .pg_ready(pg_ready),
      .pg_pulse(pg_pulse),
      .pg_start(pg_start),
      .gnt(gnt),
      .done(done),
      .err(err),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // pulse_generator model: start_delay 3, width 5
   localparam int PG_DLY = 3;
   localparam int PG_W   = 5;
   logic pulse_en;
   int   pg_cnt;
   always @(posedge clk or negedge reset) begin
      if (!reset) pg_cnt <= 0;
      else if (pg_start && pulse_en) pg_cnt <= PG_DLY + PG_W;
      else if (pg_cnt > 0) pg_cnt <= pg_cnt - 1;
   end
   assign pg_pulse = pulse_en && (pg_cnt > 0) && (pg_cnt <= PG_W);

   typedef struct {
      logic [3:0] dn;
      logic       er;
      int         starts;
      int         f2s;
      int         s2d_lo;
      int         s2d_hi;
      int         f2d;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
      end
   endtask

   task automatic push(input logic [3:0] dn, input logic er, input int starts, input int f2s,
                       input int s2d_lo, input int s2d_hi, input int f2d);
      exp_t e;
      e.dn = dn; e.er = er; e.starts = starts; e.f2s = f2s;
      e.s2d_lo = s2d_lo; e.s2d_hi = s2d_hi; e.f2d = f2d;
      exp_q.push_back(e);
   endtask

   // monitor: tracks burst timing and compares each done strobe against the scoreboard
   initial begin
      int   n_starts, last_start, last_fall, f2s_min, f2s_max;
      logic prev_pulse;
      exp_t e;
      n_starts = 0; last_start = -1; last_fall = -1; f2s_min = -1; f2s_max = -1;
      prev_pulse = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            n_starts = 0; last_start = -1; last_fall = -1; f2s_min = -1; f2s_max = -1;
            prev_pulse = 1'b0;
         end else begin
            chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (prev_pulse && !pg_pulse) last_fall = cyc;
            prev_pulse = pg_pulse;
            if (pg_start) begin
               if (n_starts > 0 && last_fall >= 0) begin
                  if (f2s_min < 0 || cyc - last_fall < f2s_min) f2s_min = cyc - last_fall;
                  if (cyc - last_fall > f2s_max) f2s_max = cyc - last_fall;
               end
               n_starts++;
               last_start = cyc;
            end
            if (done != '0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 32'(done), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("done_vec", 32'(done), 32'(e.dn));
                  chk("err_flag", 32'(err), 32'(e.er));
                  chk("gnt_at_done", 32'(gnt), 32'(e.dn));
                  chk("start_count", 32'(n_starts), 32'(e.starts));
                  if (e.f2s > 0) begin
                     chk("fall_to_start_min", 32'(f2s_min), 32'(e.f2s));
                     chk("fall_to_start_max", 32'(f2s_max), 32'(e.f2s));
                  end
                  if (e.s2d_lo > 0)
                     chk("start_to_done_window",
                         32'((cyc - last_start >= e.s2d_lo) && (cyc - last_start <= e.s2d_hi)), 32'd1);
                  if (e.f2d > 0) chk("fall_to_done", 32'(cyc - last_fall), 32'(e.f2d));
               end
               n_starts = 0; last_start = -1; last_fall = -1; f2s_min = -1; f2s_max = -1;
            end
         end
      end
   end

   task automatic wait_done(input int budget, input logic drop_on_gnt);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (drop_on_gnt && gnt != '0) begin
            req        = '0;
            req_repeat = ~req_repeat;
         end
         if (done != '0) return;
      end
      chk("wait_done_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_start(input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (pg_start) return;
      end
      chk("wait_start_timeout", 32'd0, 32'd1);
   endtask

   task automatic burst(input logic [3:0] r, input logic [15:0] rep, input logic [7:0] gap);
      req_repeat = rep;
      gap_cycles = gap;
      req        = r;
      wait_done(400, 1'b1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; req = '0; req_repeat = '0; gap_cycles = '0;
      pg_ready = 1'b0; pulse_en = 1'b1;

      // reset values and ready handshake
      #50;
      chk("rst_pg_start", 32'(pg_start), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err_busy", 32'({err, busy}), 32'd0);
      #50 reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("wait_rdy_busy", 32'(busy), 32'd1);
      chk("wait_rdy_outs", 32'({pg_start, gnt, done, err}), 32'd0);
      pg_ready = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);

      // single pulse, done one cycle after fall
      push(4'b0001, 1'b0, 1, 0, 0, 0, 1);
      burst(4'b0001, 16'h0000, 8'd0);

      // three pulses with gap 4, req and repeat changes after grant ignored
      push(4'b0010, 1'b0, 3, 5, 0, 0, 1);
      burst(4'b0010, 16'h0020, 8'd4);

      // two pulses with zero gap
      push(4'b1000, 1'b0, 2, 1, 0, 0, 1);
      burst(4'b1000, 16'h1000, 8'd0);

      // all requesting: round-robin order from bit 0
      push(4'b0001, 1'b0, 1, 0, 0, 0, 1);
      push(4'b0010, 1'b0, 1, 0, 0, 0, 1);
      push(4'b0100, 1'b0, 1, 0, 0, 0, 1);
      push(4'b1000, 1'b0, 1, 0, 0, 0, 1);
      push(4'b0001, 1'b0, 1, 0, 0, 0, 1);
      req_repeat = '0; gap_cycles = 8'd2; req = 4'b1111;
      for (int k = 0; k < 5; k++) wait_done(400, 1'b0);
      req = '0;
      repeat (3) @(negedge clk);

      // watchdog timeout with no pulse, scheduler parks in WAIT_RDY
      pulse_en = 1'b0;
      push(4'b0100, 1'b1, 1, 0, 15, 16, 0);
      req_repeat = '0; req = 4'b0100;
      wait_done(400, 1'b1);
      pg_ready = 1'b0;
      req = 4'b0001;
      repeat (5) @(negedge clk);
      chk("timeout_parked_gnt", 32'(gnt), 32'd0);
      chk("timeout_parked_busy", 32'(busy), 32'd1);
      req = '0; pg_ready = 1'b1; pulse_en = 1'b1;
      repeat (3) @(negedge clk);

      // pg_ready lost mid-burst
      push(4'b0001, 1'b1, 1, 0, 0, 0, 0);
      req_repeat = 16'h0003; gap_cycles = 8'd1; req = 4'b0001;
      wait_start(100);
      @(negedge clk);
      pg_ready = 1'b0;
      wait_done(20, 1'b1);
      repeat (3) @(negedge clk);
      chk("ready_lost_busy", 32'(busy), 32'd1);
      chk("ready_lost_gnt", 32'(gnt), 32'd0);
      pg_ready = 1'b1;
      repeat (20) @(negedge clk);
      push(4'b0001, 1'b0, 1, 0, 0, 0, 1);
      burst(4'b0001, 16'h0000, 8'd0);

      // async reset mid-burst
      req_repeat = 16'h0030; gap_cycles = 8'd2; req = 4'b0010;
      wait_start(100);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_pg_start", 32'(pg_start), 32'd0);
      chk("async_rst_gnt", 32'(gnt), 32'd0);
      chk("async_rst_done_err", 32'({done, err}), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      req = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      push(4'b0010, 1'b0, 1, 0, 0, 0, 1);
      burst(4'b0010, 16'h0000, 8'd0);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
